gfx_color_pack_wc: RTL

GFX_COLOR_PACK_WC -- requirements
Module: gfx_color_pack_wc

---
 rtl/gfx_pkg.sv | 21 ++
 rtl/gfx_color_align.sv | 40 ++++
 rtl/gfx_color_pack_wc.sv | 136 +++++++++++++
 3 files changed

// File: rtl/gfx_pkg.sv
// Shared types and helpers for the graphics colour-pack write combiner.
package gfx_pkg;

  typedef enum logic [1:0] {
    DEPTH_8BPP  = 2'd0,
    DEPTH_16BPP = 2'd1,
    DEPTH_24BPP = 2'd2,
    DEPTH_32BPP = 2'd3
  } color_depth_e;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_COLLECT,
    ST_DRAIN
  } state_e;

  function automatic logic [2:0] bytes_per_pix(input color_depth_e depth);
    return {1'b0, depth} + 3'd1;
  endfunction

endpackage

// File: rtl/gfx_color_align.sv
// Places an LSB-aligned pixel colour onto its byte lanes within one memory line.
module gfx_color_align
  import gfx_pkg::*;
#(
  parameter  int unsigned BUS_W = 256,
  localparam int unsigned NB    = BUS_W / 8,
  localparam int unsigned OFS_W = $clog2(NB)
) (
  input  logic [OFS_W-1:0] ofs,
  input  logic [31:0]      color,
  input  color_depth_e     depth,
  output logic [BUS_W-1:0] dat,
  output logic [BUS_W-1:0] mask,
  output logic [NB-1:0]    sel,
  output logic             straddle
);

  logic [2:0] nbytes;
  logic [1:0] k;

  assign nbytes   = bytes_per_pix(depth);
  assign straddle = (32'(ofs) + 32'(nbytes)) > NB;

  // Lanes past the end of the line are simply never selected, which drops the excess bytes.
  always_comb begin
    dat  = '0;
    mask = '0;
    sel  = '0;
    k    = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      if (i >= 32'(ofs) && (i - 32'(ofs)) < 32'(nbytes)) begin
        k              = 2'(i - 32'(ofs));
        sel[i]         = 1'b1;
        mask[i*8 +: 8] = '1;
        dat[i*8 +: 8]  = color[{k, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/gfx_color_pack_wc.sv
// Write combiner: merges pixel writes into one memory line and issues it as a single masked write.
module gfx_color_pack_wc
  import gfx_pkg::*;
#(
  parameter int unsigned BUS_W   = 256,
  parameter int unsigned ADR_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_valid_i,
  output logic               pix_ready_o,
  input  logic [ADR_W-1:0]   pix_adr_i,
  input  logic [31:0]        pix_color_i,
  input  logic [1:0]         color_depth_i,
  input  logic               flush_i,
  output logic               mem_valid_o,
  input  logic               mem_ready_i,
  output logic [ADR_W-1:0]   mem_adr_o,
  output logic [BUS_W-1:0]   mem_dat_o,
  output logic [BUS_W/8-1:0] mem_sel_o,
  output logic               busy_o,
  output logic               err_o
);

  localparam int unsigned NB    = BUS_W / 8;
  localparam int unsigned OFS_W = $clog2(NB);
  localparam int unsigned TAG_W = ADR_W - OFS_W;
  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [BUS_W-1:0]   dat_q, dat_d;
  logic [NB-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]   idle_q, idle_d;
  logic               err_q, err_d;

  logic [OFS_W-1:0]   pix_ofs;
  logic [TAG_W-1:0]   pix_tag;
  logic [BUS_W-1:0]   al_dat, al_mask;
  logic [NB-1:0]      al_sel;
  logic               al_straddle;
  logic               tag_hit, ready;

  assign pix_ofs = pix_adr_i[OFS_W-1:0];
  assign pix_tag = pix_adr_i[ADR_W-1:OFS_W];
  assign tag_hit = (pix_tag == tag_q);

  gfx_color_align #(
    .BUS_W (BUS_W)
  ) u_align (
    .ofs      (pix_ofs),
    .color    (pix_color_i),
    .depth    (color_depth_e'(color_depth_i)),
    .dat      (al_dat),
    .mask     (al_mask),
    .sel      (al_sel),
    .straddle (al_straddle)
  );

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    idle_d  = idle_q;
    ready   = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        ready = 1'b1;
        if (pix_valid_i) begin
          tag_d   = pix_tag;
          dat_d   = al_dat;
          sel_d   = al_sel;
          idle_d  = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        ready = tag_hit & ~flush_i;
        if (flush_i) begin
          state_d = ST_DRAIN;
        end else if (pix_valid_i && tag_hit) begin
          dat_d  = (dat_q & ~al_mask) | al_dat;
          sel_d  = sel_q | al_sel;
          idle_d = '0;
          if (&sel_d) state_d = ST_DRAIN;
        end else if (pix_valid_i) begin
          // Foreign-line pixel stays pending until this line has been written out.
          state_d = ST_DRAIN;
        end else if (TIMEOUT != 0) begin
          idle_d = idle_q + 1'b1;
          if (idle_d == CNT_W'(TIMEOUT)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_ready_i) begin
          sel_d   = '0;
          dat_d   = '0;
          idle_d  = '0;
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign err_d = pix_valid_i & ready & al_straddle;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      tag_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  assign pix_ready_o = ready;
  assign mem_valid_o = (state_q == ST_DRAIN);
  assign mem_adr_o   = {tag_q, {OFS_W{1'b0}}};
  assign mem_dat_o   = dat_q;
  assign mem_sel_o   = sel_q;
  assign busy_o      = (state_q != ST_EMPTY);
  assign err_o       = err_q;

endmodule
